keypad_emulator: RTL and testbench

Synthesizable 4x4 keypad model that answers a column-driving keypad scanner: it watches the scanner's column drive and returns the row line of one "pressed" key, with contact bounce on press and release. Used for on-chip loopback self-test and simulation of the scan/encode path without a physical matrix. A test controller requests a press of one key code; the emulator holds the contact for a programmed time, releases it, and reports completion.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_contact_timer.sv | 56 +++++
 rtl/keypad_emulator.sv | 141 ++++++++++++++
 tb/tb_keypad_emulator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad code map, FSM encoding and timing defaults
//
// Shared by the keypad scanner and the keypad emulator so both agree on the
// key-code layout: row index in bits [3:2], column index in bits [1:0].
// No ports (package).

package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } kp_state_e;

  // How the contact timer turns its bounce-phase bit into a contact level.
  typedef enum logic [1:0] {
    CM_OPEN               = 2'd0,
    CM_CLOSED             = 2'd1,
    CM_BOUNCE_CLOSED_FIRST = 2'd2,
    CM_BOUNCE_OPEN_FIRST  = 2'd3
  } contact_mode_e;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  localparam int TIMER_W = 16;

  localparam int DEFAULT_HOLD_CYCLES   = 64;
  localparam int DEFAULT_BOUNCE_CYCLES = 4;
  localparam int DEFAULT_GAP_CYCLES    = 8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/keypad_contact_timer.sv
// rtl/keypad_contact_timer.sv - shared down-counter with bounce phase, drives contact level
//
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   load         reload the counter (state entry); clears the bounce phase
//   load_value   cycles-1 of the state being entered
//   mode         contact behaviour of the current state
//   contact      1 = key contact closed this cycle
//   expire       counter at zero: current cycle is the last of the state

module keypad_contact_timer
  import keypad_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  contact_mode_e      mode,
  output logic               contact,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q;
  logic               phase_q;

  // phase_q is 0 on the first cycle of every state and toggles each cycle,
  // giving the even/odd alternation used during bounce.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else if (load) begin
      count_q <= load_value;
      phase_q <= 1'b0;
    end else begin
      if (count_q != '0) begin
        count_q <= count_q - TIMER_W'(1);
      end
      phase_q <= ~phase_q;
    end
  end

  assign expire = (count_q == '0);

  always_comb begin
    contact = 1'b0;
    case (mode)
      CM_OPEN:                contact = 1'b0;
      CM_CLOSED:              contact = 1'b1;
      CM_BOUNCE_CLOSED_FIRST: contact = ~phase_q;
      CM_BOUNCE_OPEN_FIRST:   contact = phase_q;
      default:                contact = 1'b0;
    endcase
  end

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 keypad contact model answering a column-driving scanner
//
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   Key_Code     key to press (row [3:2], column [1:0]); latched on accept
//   Press_Req    level request, only sampled while idle
//   Col          column drive from the scanner
//   Row          combinational row return (one-hot of latched row when pressed)
//   S_Row        registered OR of Row
//   Press_Ack    one-cycle pulse in the first cycle of a sequence
//   Busy         high for the whole press sequence
//   Done         one-cycle pulse in the last cycle of a sequence

module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int BOUNCE_CYCLES = DEFAULT_BOUNCE_CYCLES,
  parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Key_Code,
  input  logic       Press_Req,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       S_Row,
  output logic       Press_Ack,
  output logic       Busy,
  output logic       Done
);

  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES != 0);
  localparam bit HAS_GAP    = (GAP_CYCLES != 0);

  localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BOUNCE_LOAD = HAS_BOUNCE ? TIMER_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [TIMER_W-1:0] GAP_LOAD    = HAS_GAP ? TIMER_W'(GAP_CYCLES - 1) : '0;

  kp_state_e          state, next_state;
  contact_mode_e      mode;
  logic [3:0]         code_q;
  logic               accept;
  logic               load;
  logic [TIMER_W-1:0] load_value;
  logic               contact;
  logic               expire;

  assign accept = (state == ST_IDLE) && Press_Req;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      code_q    <= '0;
      Press_Ack <= 1'b0;
      S_Row     <= 1'b0;
    end else begin
      state     <= next_state;
      Press_Ack <= accept;
      S_Row     <= |Row;
      if (accept) begin
        code_q <= Key_Code;
      end
    end
  end

  always_comb begin
    next_state = state;
    mode       = CM_OPEN;
    case (state)
      ST_IDLE: begin
        if (Press_Req) begin
          next_state = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
        end
      end
      ST_BOUNCE_IN: begin
        mode = CM_BOUNCE_CLOSED_FIRST;
        if (expire) begin
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        mode = CM_CLOSED;
        if (expire) begin
          if (HAS_BOUNCE) begin
            next_state = ST_BOUNCE_OUT;
          end else begin
            next_state = HAS_GAP ? ST_GAP : ST_IDLE;
          end
        end
      end
      ST_BOUNCE_OUT: begin
        mode = CM_BOUNCE_OPEN_FIRST;
        if (expire) begin
          next_state = HAS_GAP ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (expire) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    // Every transition enters a different state, so a state change is
    // exactly a state entry and reloads the shared counter.
    load = (next_state != state);
    case (next_state)
      ST_BOUNCE_IN:  load_value = BOUNCE_LOAD;
      ST_HOLD:       load_value = HOLD_LOAD;
      ST_BOUNCE_OUT: load_value = BOUNCE_LOAD;
      ST_GAP:        load_value = GAP_LOAD;
      default:       load_value = '0;
    endcase
  end

  keypad_contact_timer u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (load),
    .load_value (load_value),
    .mode       (mode),
    .contact    (contact),
    .expire     (expire)
  );

  assign Busy = (state != ST_IDLE);
  // The only way back to IDLE without reset is the end of a sequence.
  assign Done = Busy && (next_state == ST_IDLE);

  // Contact is derived from registered state only, so an asynchronous
  // reset opens it without waiting for a clock.
  always_comb begin
    Row = 4'b0000;
    if (contact && Col[code_q[KEY_COL_MSB:KEY_COL_LSB]]) begin
      Row = onehot4(code_q[KEY_ROW_MSB:KEY_ROW_LSB]);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator

module tb_keypad_emulator;

  localparam int A_B = 0;
  localparam int A_H = 4;
  localparam int A_G = 2;
  localparam int B_B = 4;
  localparam int B_H = 32;
  localparam int B_G = 8;
  localparam int B_TOT = 2 * B_B + B_H + B_G;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic [3:0] a_key, a_col, a_row;
  logic       a_req, a_srow, a_ack, a_busy, a_done;
  logic [3:0] b_key, b_col, b_row;
  logic       b_req, b_srow, b_ack, b_busy, b_done;

  keypad_emulator #(.HOLD_CYCLES(A_H), .BOUNCE_CYCLES(A_B), .GAP_CYCLES(A_G)) dut_a (
    .Clk(Clk), .Reset(Reset), .Key_Code(a_key), .Press_Req(a_req), .Col(a_col),
    .Row(a_row), .S_Row(a_srow), .Press_Ack(a_ack), .Busy(a_busy), .Done(a_done)
  );

  keypad_emulator #(.HOLD_CYCLES(B_H), .BOUNCE_CYCLES(B_B), .GAP_CYCLES(B_G)) dut_b (
    .Clk(Clk), .Reset(Reset), .Key_Code(b_key), .Press_Req(b_req), .Col(b_col),
    .Row(b_row), .S_Row(b_srow), .Press_Ack(b_ack), .Busy(b_busy), .Done(b_done)
  );

  typedef struct {
    logic [3:0] row;
    logic       srow;
    logic       ack;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
  } sel_t;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input vec_t v);
    chk($sformatf("%s_row", tag),  32'(a_row),  32'(v.row));
    chk($sformatf("%s_srow", tag), 32'(a_srow), 32'(v.srow));
    chk($sformatf("%s_ack", tag),  32'(a_ack),  32'(v.ack));
    chk($sformatf("%s_busy", tag), 32'(a_busy), 32'(v.busy));
    chk($sformatf("%s_done", tag), 32'(a_done), 32'(v.done));
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input bit use_b, input int lim, input string name);
    int n = 0;
    while ((use_b ? b_busy : a_busy) && n < lim) begin
      next_cycle();
      n++;
    end
    chk(name, 32'(use_b ? b_busy : a_busy), 32'd0);
    next_cycle();
  endtask

  // Contact level k cycles after accept: bounce-in (closed on even),
  // solid hold, bounce-out (closed on odd), then open gap.
  function automatic bit contact_at(input int k, input int nb, input int nh);
    if (k < nb) return (k % 2) == 0;
    if (k < nb + nh) return 1'b1;
    if (k < 2 * nb + nh) return ((k - nb - nh) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_row(input bit c, input logic [3:0] code, input logic [3:0] col);
    if (c && col[code[1:0]]) return 4'b0001 << code[3:2];
    return 4'b0000;
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    if (v[3]) return 2'd3;
    if (v[2]) return 2'd2;
    if (v[1]) return 2'd1;
    return 2'd0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t basic[7];
    sel_t sel[7];
    int hits;
    int scan;
    logic [3:0] code;
    bit   m_busy;
    int   m_k;
    logic [3:0] m_code;
    logic [3:0] er;
    logic [3:0] prev_row;

    basic[0] = '{4'b0010, 1'b0, 1'b1, 1'b1, 1'b0};
    basic[1] = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0};
    basic[2] = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0};
    basic[3] = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0};
    basic[4] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    basic[5] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
    basic[6] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};

    sel[0] = '{4'b0001, 4'b0000};
    sel[1] = '{4'b0010, 4'b0000};
    sel[2] = '{4'b0100, 4'b0000};
    sel[3] = '{4'b1000, 4'b0100};
    sel[4] = '{4'b1111, 4'b0100};
    sel[5] = '{4'b0111, 4'b0000};
    sel[6] = '{4'b1001, 4'b0100};

    a_key = '0; a_col = '0; a_req = 1'b0;
    b_key = '0; b_col = '0; b_req = 1'b0;
    Reset = 1'b1;

    // reset state
    repeat (2) @(posedge Clk);
    a_col = 4'b1111;
    b_col = 4'b1111;
    @(negedge Clk);
    chk("rst_a_row",  32'(a_row),  32'd0);
    chk("rst_a_srow", 32'(a_srow), 32'd0);
    chk("rst_a_ack",  32'(a_ack),  32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_b_row",  32'(b_row),  32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    next_cycle();
    Reset = 1'b0;
    next_cycle();

    // basic press, no bounce
    a_col = 4'b0100; a_key = 4'h6; a_req = 1'b1;
    next_cycle();
    a_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      chk_a($sformatf("basic%0d", i), basic[i]);
      next_cycle();
    end

    // request while busy is ignored, held request accepted after Busy falls
    a_key = 4'h6; a_req = 1'b1;
    next_cycle();
    a_req = 1'b0;
    @(negedge Clk);
    chk("busyreq_ack0", 32'(a_ack), 32'd1);
    next_cycle();
    a_req = 1'b1; a_key = 4'hF;
    for (int i = 1; i < 6; i++) begin
      @(negedge Clk);
      chk_a($sformatf("busyreq%0d", i), basic[i]);
      next_cycle();
    end
    a_col = 4'b1000;
    @(negedge Clk);
    chk("busyreq_idle_busy", 32'(a_busy), 32'd0);
    chk("busyreq_idle_ack",  32'(a_ack),  32'd0);
    next_cycle();
    a_req = 1'b0;
    @(negedge Clk);
    chk("busyreq_new_ack",  32'(a_ack),  32'd1);
    chk("busyreq_new_busy", 32'(a_busy), 32'd1);
    chk("busyreq_new_row",  32'(a_row),  32'h8);
    next_cycle();
    wait_idle(1'b0, 20, "busyreq_timeout");

    // asynchronous reset mid-hold
    a_key = 4'h9; a_col = 4'b0010; a_req = 1'b1;
    next_cycle();
    a_req = 1'b0;
    next_cycle();
    @(negedge Clk);
    chk("rstmid_pre_row", 32'(a_row), 32'h4);
    #2;
    Reset = 1'b1;
    #1;
    chk("rstmid_row",  32'(a_row),  32'd0);
    chk("rstmid_busy", 32'(a_busy), 32'd0);
    chk("rstmid_done", 32'(a_done), 32'd0);
    next_cycle();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk($sformatf("rstmid_nodone%0d", i), 32'(a_done), 32'd0);
      chk($sformatf("rstmid_idle%0d", i),   32'(a_busy), 32'd0);
      next_cycle();
    end

    // column selectivity during hold
    b_key = 4'hB; b_col = 4'b1111; b_req = 1'b1;
    next_cycle();
    b_req = 1'b0;
    repeat (5) next_cycle();
    for (int i = 0; i < 7; i++) begin
      b_col = sel[i].col;
      #1;
      chk($sformatf("sel_col%0h", sel[i].col), 32'(b_row), 32'(sel[i].row));
    end
    wait_idle(1'b1, 100, "sel_timeout");

    // bounce pattern on all columns
    b_key = 4'h0; b_col = 4'b1111; b_req = 1'b1;
    next_cycle();
    b_req = 1'b0;
    for (int k = 0; k <= B_TOT; k++) begin
      @(negedge Clk);
      chk($sformatf("bounce_row%0d", k),  32'(b_row),  32'(contact_at(k, B_B, B_H) ? 4'b0001 : 4'b0000));
      chk($sformatf("bounce_busy%0d", k), 32'(b_busy), 32'(k < B_TOT));
      chk($sformatf("bounce_done%0d", k), 32'(b_done), 32'(k == B_TOT - 1));
      next_cycle();
    end

    // loopback with a simple column scanner
    b_key = 4'hD; b_col = 4'b0001; b_req = 1'b1;
    next_cycle();
    b_req = 1'b0;
    hits = 0;
    scan = 0;
    for (int c = 0; c < B_TOT + 4; c++) begin
      b_col = 4'b0001 << scan;
      scan = (scan + 1) % 4;
      @(negedge Clk);
      if (b_row != 4'b0000) begin
        hits++;
        code = {enc4(b_row), enc4(b_col)};
        chk("loop_code", 32'(code), 32'd13);
      end
      next_cycle();
    end
    chk("loop_valid", 32'(hits > 0), 32'd1);
    chk("loop_idle",  32'(b_busy),   32'd0);

    // randomized traffic against the schedule model
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    m_busy = 1'b0;
    m_k = 0;
    m_code = '0;
    prev_row = '0;
    for (int it = 0; it < 1500; it++) begin
      b_req = ($urandom % 4) == 0;
      b_key = 4'($urandom);
      case ($urandom % 3)
        0: b_col = 4'b0001 << $urandom_range(3);
        1: b_col = 4'b1111;
        default: b_col = 4'($urandom);
      endcase
      @(negedge Clk);
      er = exp_row(m_busy && contact_at(m_k, B_B, B_H), m_code, b_col);
      chk("rnd_row",  32'(b_row),  32'(er));
      chk("rnd_srow", 32'(b_srow), 32'(|prev_row));
      chk("rnd_ack",  32'(b_ack),  32'(m_busy && m_k == 0));
      chk("rnd_busy", 32'(b_busy), 32'(m_busy));
      chk("rnd_done", 32'(b_done), 32'(m_busy && m_k == B_TOT - 1));
      prev_row = er;
      next_cycle();
      if (m_busy) begin
        m_k++;
        if (m_k == B_TOT) m_busy = 1'b0;
      end else if (b_req) begin
        m_busy = 1'b1;
        m_k = 0;
        m_code = b_key;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
